musb_gpr_write_arbiter: RTL and testbench

Write-side arbiter for the single write port of the 32×32 general-purpose register file. It merges the in-order pipeline writeback stream with out-of-order results from long-latency units (multiplier/divider, uncached loads). It buffers those results in a small FIFO and drains them into idle writeback slots. It also keeps a per-register pending scoreboard, which decode uses to stall on RAW and WAW hazards against outstanding results.

---
 rtl/musb_gpr_write_arbiter_if.sv | 23 ++
 rtl/musb_gpr_write_arbiter.sv | 127 ++++++++++++
 tb/tb_musb_gpr_write_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/musb_gpr_write_arbiter_if.sv
// rtl/musb_gpr_write_arbiter_if.sv - long-latency result handshake channel into the GPR write arbiter
interface musb_gpr_write_arbiter_if;
   logic        async_valid;
   logic [4:0]  async_wa;
   logic [31:0] async_wd;
   logic        async_ready;

   // Result producer side (multiplier/divider, uncached load unit)
   modport master (
      output async_valid,
      output async_wa,
      output async_wd,
      input  async_ready
   );

   // Arbiter side
   modport slave (
      input  async_valid,
      input  async_wa,
      input  async_wd,
      output async_ready
   );
endinterface

// File: rtl/musb_gpr_write_arbiter.sv
// rtl/musb_gpr_write_arbiter.sv - GPR write-port arbiter with async result FIFO and pending scoreboard
module musb_gpr_write_arbiter #(
   parameter int DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   // In-order pipeline writeback; always has priority and is never stalled
   input  logic [4:0]                wb_gpr_wa,
   input  logic [31:0]               wb_gpr_wd,
   input  logic                      wb_gpr_we,
   // Long-latency op issue, marks the destination as outstanding
   input  logic                      async_issue,
   input  logic [4:0]                async_issue_wa,
   // Long-latency result channel
   musb_gpr_write_arbiter_if.slave   async,
   // Decode hazard lookup
   input  logic [4:0]                id_ra_a,
   input  logic [4:0]                id_ra_b,
   input  logic [4:0]                id_wa,
   output logic                      hazard_stall,
   // Register file write port
   output logic [4:0]                gpr_wa,
   output logic [31:0]               gpr_wd,
   output logic                      gpr_we
);

   // DEPTH must be a power of two >= 2 so the extra pointer bit distinguishes full from empty.
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [4:0]    fifo_wa [DEPTH];
   logic [31:0]   fifo_wd [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   logic          fifo_full;
   logic          fifo_empty;
   logic          slot_busy;
   logic          push;
   logic          pop;
   logic [4:0]    head_wa;
   logic [31:0]   head_wd;

   logic [31:0]   pending_q;
   logic [31:0]   set_vec;
   logic [31:0]   clr_vec;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   // Writes to r0 occupy no slot, so the FIFO may drain underneath them.
   assign slot_busy  = wb_gpr_we && (wb_gpr_wa != 5'd0);

   // Ready ignores a same-cycle pop: there is no push-through path when full.
   assign async.async_ready = !fifo_full && !rst;

   // Results aimed at r0 are handshaken but dropped, never stored.
   assign push = async.async_valid && async.async_ready && (async.async_wa != 5'd0);
   assign pop  = !slot_busy && !fifo_empty;

   assign head_wa = fifo_wa[rd_ptr[AW-1:0]];
   assign head_wd = fifo_wd[rd_ptr[AW-1:0]];

   // Result storage; contents are only meaningful between the pointers, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_wa[wr_ptr[AW-1:0]] <= async.async_wa;
         fifo_wd[wr_ptr[AW-1:0]] <= async.async_wd;
      end
   end

   // FIFO pointers; reset discards every buffered result.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   // Write-port mux: pipeline first, then FIFO head, otherwise a quiet port.
   always_comb begin
      gpr_we = 1'b0;
      gpr_wa = 5'd0;
      gpr_wd = 32'd0;
      if (slot_busy) begin
         gpr_we = wb_gpr_we;
         gpr_wa = wb_gpr_wa;
         gpr_wd = wb_gpr_wd;
      end else if (!fifo_empty) begin
         gpr_we = 1'b1;
         gpr_wa = head_wa;
         gpr_wd = head_wd;
      end
   end

   // Scoreboard set/clear vectors for this cycle; r0 never becomes pending.
   always_comb begin
      set_vec = 32'd0;
      clr_vec = 32'd0;
      if (async_issue && (async_issue_wa != 5'd0)) begin
         set_vec[async_issue_wa] = 1'b1;
      end
      if (pop) begin
         clr_vec[head_wa] = 1'b1;
      end
   end

   // Pending register update; applying the set after the clear makes a same-register issue win.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= 32'd0;
      end else begin
         pending_q <= ((pending_q & ~clr_vec) | set_vec) & ~32'd1;
      end
   end

   // RAW on either source or WAW on the destination against an outstanding result.
   assign hazard_stall = pending_q[id_ra_a] | pending_q[id_ra_b] | pending_q[id_wa];

endmodule

// File: tb/tb_musb_gpr_write_arbiter.sv
// tb/tb_musb_gpr_write_arbiter.sv - scoreboard bench for the GPR write arbiter
module tb_musb_gpr_write_arbiter;

   typedef struct packed {
      logic [4:0]  wa;
      logic [31:0] wd;
   } res_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  wb_gpr_wa;
   logic [31:0] wb_gpr_wd;
   logic        wb_gpr_we;
   logic        async_issue;
   logic [4:0]  async_issue_wa;
   logic [4:0]  id_ra_a;
   logic [4:0]  id_ra_b;
   logic [4:0]  id_wa;
   logic        hazard_stall;
   logic [4:0]  gpr_wa;
   logic [31:0] gpr_wd;
   logic        gpr_we;

   int   vectors = 0;
   int   miscompares = 0;
   res_t sb[$];

   musb_gpr_write_arbiter_if aif ();

   musb_gpr_write_arbiter #(.DEPTH(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .wb_gpr_wa      (wb_gpr_wa),
      .wb_gpr_wd      (wb_gpr_wd),
      .wb_gpr_we      (wb_gpr_we),
      .async_issue    (async_issue),
      .async_issue_wa (async_issue_wa),
      .async          (aif.slave),
      .id_ra_a        (id_ra_a),
      .id_ra_b        (id_ra_b),
      .id_wa          (id_wa),
      .hazard_stall   (hazard_stall),
      .gpr_wa         (gpr_wa),
      .gpr_wd         (gpr_wd),
      .gpr_we         (gpr_we)
   );

   always #5 clk = ~clk;

   task automatic go();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      wb_gpr_wa = 5'd0; wb_gpr_wd = 32'd0; wb_gpr_we = 1'b0;
      async_issue = 1'b0; async_issue_wa = 5'd0;
      aif.async_valid = 1'b0; aif.async_wa = 5'd0; aif.async_wd = 32'd0;
      id_ra_a = 5'd0; id_ra_b = 5'd0; id_wa = 5'd0;
   endtask

   task automatic offer(input logic [4:0] wa, input logic [31:0] wd, input bit expect_store);
      aif.async_valid = 1'b1; aif.async_wa = wa; aif.async_wd = wd;
      if (expect_store) sb.push_back({wa, wd});
   endtask

   task automatic expect_fifo_write(input string name);
      res_t e;
      vectors++;
      if (sb.size() == 0) begin
         miscompares++;
         $display("FAIL %s scoreboard empty, got we=%0b wa=%0d", name, gpr_we, gpr_wa);
      end else begin
         e = sb.pop_front();
         if ({gpr_we, gpr_wa, gpr_wd} !== {1'b1, e.wa, e.wd}) begin
            miscompares++;
            $display("FAIL %s got we=%0b wa=%0d wd=%h exp we=1 wa=%0d wd=%h",
                     name, gpr_we, gpr_wa, gpr_wd, e.wa, e.wd);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; clear_inputs();
      go(); sample();
      vectors++; if (aif.async_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready_in_rst got=%0b exp=0", aif.async_ready); end
      go(); rst = 1'b0; id_ra_a = 5'd5; sample();
      vectors++; if (gpr_we !== 1'b0) begin miscompares++; $display("FAIL reset_gpr_we got=%0b exp=0", gpr_we); end
      vectors++; if (aif.async_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%0b exp=1", aif.async_ready); end
      vectors++; if (hazard_stall !== 1'b0) begin miscompares++; $display("FAIL reset_hazard got=%0b exp=0", hazard_stall); end
   endtask

   task automatic test_idle_drain();
      go(); clear_inputs(); async_issue = 1'b1; async_issue_wa = 5'd7; id_ra_a = 5'd7; sample();
      vectors++; if (hazard_stall !== 1'b0) begin miscompares++; $display("FAIL drain_hazard_issue_cycle got=%0b exp=0", hazard_stall); end
      go(); async_issue = 1'b0; offer(5'd7, 32'hDEADBEEF, 1'b1); sample();
      vectors++; if (hazard_stall !== 1'b1) begin miscompares++; $display("FAIL drain_hazard_pending got=%0b exp=1", hazard_stall); end
      vectors++; if (aif.async_ready !== 1'b1) begin miscompares++; $display("FAIL drain_ready got=%0b exp=1", aif.async_ready); end
      vectors++; if (gpr_we !== 1'b0) begin miscompares++; $display("FAIL drain_no_same_cycle got=%0b exp=0", gpr_we); end
      go(); aif.async_valid = 1'b0; sample();
      expect_fifo_write("drain_write");
      vectors++; if (hazard_stall !== 1'b1) begin miscompares++; $display("FAIL drain_hazard_write_cycle got=%0b exp=1", hazard_stall); end
      go(); sample();
      vectors++; if (hazard_stall !== 1'b0) begin miscompares++; $display("FAIL drain_hazard_cleared got=%0b exp=0", hazard_stall); end
      vectors++; if (gpr_we !== 1'b0) begin miscompares++; $display("FAIL drain_idle_after got=%0b exp=0", gpr_we); end
   endtask

   task automatic test_priority();
      go(); clear_inputs();
      wb_gpr_we = 1'b1; wb_gpr_wa = 5'd3; wb_gpr_wd = 32'h11;
      offer(5'd9, 32'h0000_0099, 1'b1);
      for (int i = 0; i < 5; i++) begin
         sample();
         vectors++;
         if ({gpr_we, gpr_wa, gpr_wd} !== {1'b1, 5'd3, 32'h11}) begin
            miscompares++;
            $display("FAIL prio_wb_cycle%0d got we=%0b wa=%0d wd=%h exp we=1 wa=3 wd=11", i, gpr_we, gpr_wa, gpr_wd);
         end
         go(); aif.async_valid = 1'b0;
      end
      wb_gpr_we = 1'b0; sample();
      expect_fifo_write("prio_first_idle");
      go(); sample();
      vectors++; if (gpr_we !== 1'b0) begin miscompares++; $display("FAIL prio_drained got=%0b exp=0", gpr_we); end
   endtask

   task automatic test_full();
      go(); clear_inputs();
      wb_gpr_we = 1'b1; wb_gpr_wa = 5'd3; wb_gpr_wd = 32'h11;
      offer(5'd10, 32'hA0A0_A0A0, 1'b1); sample();
      vectors++; if (aif.async_ready !== 1'b1) begin miscompares++; $display("FAIL full_ready_1 got=%0b exp=1", aif.async_ready); end
      go(); offer(5'd11, 32'hB0B0_B0B0, 1'b1); sample();
      vectors++; if (aif.async_ready !== 1'b1) begin miscompares++; $display("FAIL full_ready_2 got=%0b exp=1", aif.async_ready); end
      go(); aif.async_valid = 1'b0; sample();
      vectors++; if (aif.async_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready_3 got=%0b exp=0", aif.async_ready); end
      go(); wb_gpr_we = 1'b0; offer(5'd12, 32'hC0C0_C0C0, 1'b0); sample();
      vectors++; if (aif.async_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready_pop_cycle got=%0b exp=0", aif.async_ready); end
      expect_fifo_write("full_order_0");
      go(); aif.async_valid = 1'b0; sample();
      vectors++; if (aif.async_ready !== 1'b1) begin miscompares++; $display("FAIL full_ready_after_pop got=%0b exp=1", aif.async_ready); end
      expect_fifo_write("full_order_1");
      go(); sample();
      vectors++; if (gpr_we !== 1'b0) begin miscompares++; $display("FAIL full_rejected_not_written got=%0b exp=0", gpr_we); end
   endtask

   task automatic test_scoreboard();
      go(); clear_inputs(); async_issue = 1'b1; async_issue_wa = 5'd4;
      go(); async_issue_wa = 5'd5;
      go(); async_issue = 1'b0; offer(5'd4, 32'h44, 1'b1);
      id_ra_b = 5'd4; sample();
      vectors++; if (hazard_stall !== 1'b1) begin miscompares++; $display("FAIL sb_ra_b_4 got=%0b exp=1", hazard_stall); end
      id_ra_b = 5'd0; id_wa = 5'd5; #1;
      vectors++; if (hazard_stall !== 1'b1) begin miscompares++; $display("FAIL sb_wa_5 got=%0b exp=1", hazard_stall); end
      id_wa = 5'd0; id_ra_a = 5'd0; #1;
      vectors++; if (hazard_stall !== 1'b0) begin miscompares++; $display("FAIL sb_ra_a_0 got=%0b exp=0", hazard_stall); end
      go(); aif.async_valid = 1'b0; async_issue = 1'b1; async_issue_wa = 5'd4; id_ra_a = 5'd4; sample();
      expect_fifo_write("sb_complete_r4");
      go(); async_issue = 1'b0; sample();
      vectors++; if (hazard_stall !== 1'b1) begin miscompares++; $display("FAIL sb_set_wins got=%0b exp=1", hazard_stall); end
   endtask

   task automatic test_zero_reg();
      go(); clear_inputs(); offer(5'd0, 32'h123, 1'b0); sample();
      vectors++; if (aif.async_ready !== 1'b1) begin miscompares++; $display("FAIL zero_ready got=%0b exp=1", aif.async_ready); end
      go(); aif.async_valid = 1'b0; sample();
      vectors++; if (gpr_we !== 1'b0) begin miscompares++; $display("FAIL zero_no_write got=%0b exp=0", gpr_we); end
      go(); wb_gpr_we = 1'b1; wb_gpr_wa = 5'd3; wb_gpr_wd = 32'h11; offer(5'd12, 32'hC1, 1'b1);
      go(); offer(5'd0, 32'h55, 1'b0); sample();
      vectors++; if (aif.async_ready !== 1'b1) begin miscompares++; $display("FAIL zero_ready_count1 got=%0b exp=1", aif.async_ready); end
      go(); offer(5'd13, 32'hD1, 1'b1); sample();
      vectors++; if (aif.async_ready !== 1'b1) begin miscompares++; $display("FAIL zero_count_unchanged got=%0b exp=1", aif.async_ready); end
      go(); aif.async_valid = 1'b0; wb_gpr_wa = 5'd0; wb_gpr_wd = 32'h77; sample();
      vectors++; if (aif.async_ready !== 1'b0) begin miscompares++; $display("FAIL zero_full got=%0b exp=0", aif.async_ready); end
      expect_fifo_write("zero_wb_r0_drain_0");
      go(); sample();
      expect_fifo_write("zero_wb_r0_drain_1");
      go(); wb_gpr_we = 1'b0; sample();
      vectors++; if (gpr_we !== 1'b0) begin miscompares++; $display("FAIL zero_empty_after got=%0b exp=0", gpr_we); end
   endtask

   task automatic test_reset_mid();
      go(); clear_inputs(); wb_gpr_we = 1'b1; wb_gpr_wa = 5'd3; wb_gpr_wd = 32'h11;
      offer(5'd20, 32'h2020, 1'b1);
      go(); offer(5'd21, 32'h2121, 1'b1);
      go(); aif.async_valid = 1'b0; wb_gpr_we = 1'b0; rst = 1'b1; sample();
      vectors++; if (aif.async_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_ready got=%0b exp=0", aif.async_ready); end
      sb.delete();
      go(); rst = 1'b0; id_ra_a = 5'd4; id_wa = 5'd5;
      for (int i = 0; i < 3; i++) begin
         sample();
         vectors++;
         if ({gpr_we, aif.async_ready, hazard_stall} !== 3'b010) begin
            miscompares++;
            $display("FAIL rstmid_after%0d got we=%0b ready=%0b stall=%0b exp we=0 ready=1 stall=0", i, gpr_we, aif.async_ready, hazard_stall);
         end
         go();
      end
      rst = 1'b1; offer(5'd25, 32'h2525, 1'b0); sample();
      vectors++; if (aif.async_ready !== 1'b0) begin miscompares++; $display("FAIL rst_accept_ready got=%0b exp=0", aif.async_ready); end
      go(); rst = 1'b0; aif.async_valid = 1'b0; sample();
      vectors++; if (gpr_we !== 1'b0) begin miscompares++; $display("FAIL rst_accept_dropped got=%0b exp=0", gpr_we); end
   endtask

   initial begin
      test_reset();
      test_idle_drain();
      test_priority();
      test_full();
      test_scoreboard();
      test_zero_reg();
      test_reset_mid();
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
